// File: rtl/seq_shift_add_multiplier.sv
// ---------------------------------------------------------------------------
// seq_shift_add_multiplier
// Multi-cycle multiplier for the execution datapath. Each operation takes
// WIDTH iterations. Unsigned operations use shift-add. Signed operations use
// radix-2 Booth recoding. The result stays registered until the next
// operation completes.
//
// Ports
//   clk              in   1        clock, all state updates on posedge
//   rst              in   1        asynchronous reset, active low
//   start            in   1        request, sampled only in IDLE or DONE
//   signed_mode      in   1        1 = two's-complement operands, 0 = unsigned
//   multiplicand_in  in   WIDTH    operand A, captured on accepted start
//   multiplier_in    in   WIDTH    operand B, captured on accepted start
//   busy             out  1        1 while iterating (CALC)
//   ready            out  1        1 in DONE, product_out valid
//   product_out      out  2*WIDTH  final product, registered
// ---------------------------------------------------------------------------
module seq_shift_add_multiplier #(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     multiplicand_in,
    input  logic [WIDTH-1:0]     multiplier_in,
    output logic                 busy,
    output logic                 ready,
    output logic [2*WIDTH-1:0]   product_out
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_busy;
    logic               r_ready;
    logic               w_busy_nxt;
    logic               w_ready_nxt;

    logic [WIDTH-1:0]   r_m;
    logic               r_mode;
    // One guard bit above WIDTH so that subtracting -2^(WIDTH-1) cannot overflow
    logic [WIDTH:0]     r_u;
    logic [WIDTH-1:0]   r_p;
    logic               r_q1;
    logic [CNT_W-1:0]   r_cnt;
    logic [2*WIDTH-1:0] r_product;

    logic [WIDTH:0]     w_m_ext;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_u_nxt;
    logic [WIDTH-1:0]   w_p_nxt;
    logic               w_q1_nxt;
    logic               w_accept;
    logic               w_last;

    assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_last   = (r_state == S_CALC) && (r_cnt == CNT_W'(WIDTH - 1));

    // State register, with busy/ready registered alongside the state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_ready <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= w_busy_nxt;
            r_ready <= w_ready_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) w_state_nxt = S_CALC;
                else       w_state_nxt = S_IDLE;
            end
            S_CALC: begin
                if (w_last) w_state_nxt = S_DONE;
                else        w_state_nxt = S_CALC;
            end
            S_DONE: begin
                if (start) w_state_nxt = S_CALC;
                else       w_state_nxt = S_DONE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output decode from the next state so busy/ready can come straight from flops
    always_comb begin
        w_busy_nxt  = (w_state_nxt == S_CALC);
        w_ready_nxt = (w_state_nxt == S_DONE);
    end

    // Add/subtract step: unsigned adds M when P[0] is set, Booth looks at {P[0],q_1}
    always_comb begin
        w_m_ext = r_mode ? {r_m[WIDTH-1], r_m} : {1'b0, r_m};
        w_sum   = r_u;
        if (r_mode) begin
            case ({r_p[0], r_q1})
                2'b01:   w_sum = r_u + w_m_ext;
                2'b10:   w_sum = r_u - w_m_ext;
                default: w_sum = r_u;
            endcase
        end else begin
            if (r_p[0]) w_sum = r_u + w_m_ext;
            else        w_sum = r_u;
        end
    end

    // Right shift of {U,P,q_1}. Signed mode replicates the sign bit. Unsigned
    // mode feeds the carry into U[WIDTH-1] and clears the guard bit.
    always_comb begin
        w_u_nxt  = {(r_mode ? w_sum[WIDTH] : 1'b0), w_sum[WIDTH:1]};
        w_p_nxt  = {w_sum[0], r_p[WIDTH-1:1]};
        w_q1_nxt = r_p[0];
    end

    // Operand capture and iteration registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_m    <= {WIDTH{1'b0}};
            r_mode <= 1'b0;
            r_u    <= {(WIDTH+1){1'b0}};
            r_p    <= {WIDTH{1'b0}};
            r_q1   <= 1'b0;
            r_cnt  <= {CNT_W{1'b0}};
        end else if (w_accept) begin
            r_m    <= multiplicand_in;
            r_mode <= signed_mode;
            r_u    <= {(WIDTH+1){1'b0}};
            r_p    <= multiplier_in;
            r_q1   <= 1'b0;
            r_cnt  <= {CNT_W{1'b0}};
        end else if (r_state == S_CALC) begin
            r_u    <= w_u_nxt;
            r_p    <= w_p_nxt;
            r_q1   <= w_q1_nxt;
            r_cnt  <= r_cnt + CNT_W'(1);
        end
    end

    // Result register: loads only on the last iteration, so it holds the
    // previous result while a new operation is running
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_product <= {(2*WIDTH){1'b0}};
        end else if (w_last) begin
            r_product <= {w_u_nxt[WIDTH-1:0], w_p_nxt};
        end
    end

    assign busy        = r_busy;
    assign ready       = r_ready;
    assign product_out = r_product;

endmodule
